load_data_unit: RTL

Memory-stage load path for the rv32i core. It is the counterpart of the store byte-enable/data-shift logic and is the read side of the same BRAM data port. On a load request it issues a word-aligned read to the data BRAM and waits the BRAM's fixed read latency. It then extracts the addressed byte, halfword or word, sign- or zero-extends it per func3, and returns it to writeback with a one-cycle valid pulse. It stalls the core while the read is in flight and flags misaligned or illegal loads without touching memory.

---
 rtl/load_data_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/load_data_unit.sv
// rv32i MEM-stage load path: word-aligned BRAM read, byte/half/word extract and extend, BRAM_LATENCY+2 cycles to ld_valid.
// Stalls the core via combinational ld_busy while a read is in flight; faults skip memory and pulse a flag one cycle after accept.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FUNC3_WIDTH
`define FUNC3_WIDTH 3
`endif

module load_data_unit #(
   parameter int BRAM_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ld_req,
   input  logic [`DATA_WIDTH-1:0]   ld_addr,
   input  logic [`FUNC3_WIDTH-1:0]  ld_func3,
   input  logic [4:0]               ld_rd,
   output logic                     mem_rd_en,
   output logic [`DATA_WIDTH-1:0]   mem_addr,
   input  logic [`DATA_WIDTH-1:0]   mem_rdata,
   output logic                     ld_busy,
   output logic                     ld_valid,
   output logic [`DATA_WIDTH-1:0]   ld_data,
   output logic [4:0]               ld_rd_out,
   output logic                     ld_misaligned,
   output logic                     ld_illegal
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [`FUNC3_WIDTH-1:0] F_LB  = `FUNC3_WIDTH'('b000);
   localparam logic [`FUNC3_WIDTH-1:0] F_LH  = `FUNC3_WIDTH'('b001);
   localparam logic [`FUNC3_WIDTH-1:0] F_LW  = `FUNC3_WIDTH'('b010);
   localparam logic [`FUNC3_WIDTH-1:0] F_LBU = `FUNC3_WIDTH'('b100);
   localparam logic [`FUNC3_WIDTH-1:0] F_LHU = `FUNC3_WIDTH'('b101);

   localparam logic [1:0] CNT_INIT = 2'(BRAM_LATENCY - 1);

   logic [1:0]               state_q, state_d;
   logic [1:0]               off_q, off_d;
   logic [`FUNC3_WIDTH-1:0]  func3_q, func3_d;
   logic [4:0]               rd_q, rd_d;
   logic [`DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [`DATA_WIDTH-1:0]   data_q, data_d;
   logic                     rd_en_q, rd_en_d;
   logic                     valid_q, valid_d;
   logic                     mis_q, mis_d;
   logic                     ill_q, ill_d;

   logic                     req_illegal;
   logic                     req_misaligned;
   logic [7:0]               byte_sel;
   logic [15:0]              half_sel;
   logic [`DATA_WIDTH-1:0]   ext;

   // Illegal takes priority so an unsupported func3 never also reports misalignment.
   always_comb begin
      req_illegal = 1'b1;
      case (ld_func3)
         F_LB, F_LH, F_LW, F_LBU, F_LHU: req_illegal = 1'b0;
         default:                        req_illegal = 1'b1;
      endcase
      req_misaligned = !req_illegal &&
                       ((ld_func3[1:0] == 2'b01 && ld_addr[0]) ||
                        (ld_func3[1:0] == 2'b10 && ld_addr[1:0] != 2'b00));
   end

   always_comb begin
      byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (func3_q)
         F_LB:    ext = {{(`DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F_LBU:   ext = {{(`DATA_WIDTH-8){1'b0}}, byte_sel};
         F_LH:    ext = {{(`DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F_LHU:   ext = {{(`DATA_WIDTH-16){1'b0}}, half_sel};
         default: ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      func3_d = func3_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rd_en_d = 1'b0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      ill_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ld_req) begin
               off_d   = ld_addr[1:0];
               func3_d = ld_func3;
               rd_d    = ld_rd;
               addr_d  = {ld_addr[`DATA_WIDTH-1:2], 2'b00};
               if (req_illegal || req_misaligned) begin
                  state_d = S_RESP;
                  ill_d   = req_illegal;
                  mis_d   = req_misaligned;
               end else begin
                  state_d = S_REQ;
                  rd_en_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               data_d  = ext;
               valid_d = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;  // RESP: the held request is the same instruction, never re-issue
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         off_q   <= 2'd0;
         func3_q <= '0;
         rd_q    <= 5'd0;
         addr_q  <= '0;
         cnt_q   <= 2'd0;
         data_q  <= '0;
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         func3_q <= func3_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rd_en_q <= rd_en_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
      end
   end

   assign ld_busy       = (state_q == S_IDLE && ld_req) || state_q == S_REQ || state_q == S_WAIT;
   assign mem_rd_en     = rd_en_q;
   assign mem_addr      = addr_q;
   assign ld_valid      = valid_q;
   assign ld_data       = data_q;
   assign ld_rd_out     = rd_q;
   assign ld_misaligned = mis_q;
   assign ld_illegal    = ill_q;

endmodule
